// File: rtl/alu_bist.sv
// Built-in self-test initiator for the execute-stage ALU: sweeps every opcode with
// directed corner vectors then LFSR vectors, compresses results and flags into a MISR.

package alu_bist_pkg;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h1D87_2B41,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output aluop_t      opcode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [4:0]  shamt,
  input  logic [31:0] res,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_v
);

  localparam int unsigned     VW       = $clog2(NUM_VECTORS);
  localparam logic [VW-1:0]   LAST_VEC = VW'(NUM_VECTORS - 1);
  localparam logic [3:0]      LAST_OP  = 4'd9;
  localparam logic [31:0]     SEED_B   = {SEED[15:0], SEED[31:16]};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] lfsrStep(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  // The first four vectors of every opcode are fixed corner cases; the rest come from the LFSRs.
  function automatic logic [63:0] pickOperands(input logic [VW-1:0] v,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] ops;
    case (v)
      VW'(0):  ops = {32'h7FFF_FFFF, 32'h0000_0001};
      VW'(1):  ops = {32'h8000_0000, 32'h8000_0000};
      VW'(2):  ops = {32'h0000_0000, 32'h0000_0000};
      VW'(3):  ops = {32'hFFFF_FFFF, 32'h0000_001F};
      default: ops = {a, b};
    endcase
    return ops;
  endfunction

  state_t        state_q;
  logic [VW-1:0] vecCnt_q, vecCnt_d;
  logic [3:0]    opIdx_q, opIdx_d;
  logic [31:0]   lfsrA_q, lfsrA_d;
  logic [31:0]   lfsrB_q, lfsrB_d;
  logic [31:0]   sig_q, sig_d;
  aluop_t        opcode_q;
  logic [31:0]   op1_q, op2_q;
  logic [63:0]   opnd_d;
  logic          busy_q, done_q, pass_q;
  logic          lastVec, lastOp;

  always_comb begin
    lastVec  = (vecCnt_q == LAST_VEC);
    lastOp   = (opIdx_q == LAST_OP);
    sig_d    = lfsrStep(sig_q) ^ res ^ {29'b0, flag_n, flag_z, flag_v};
    lfsrA_d  = lfsrStep(lfsrA_q);
    lfsrB_d  = lfsrStep(lfsrB_q);
    vecCnt_d = lastVec ? '0 : vecCnt_q + VW'(1);
    opIdx_d  = lastVec ? opIdx_q + 4'd1 : opIdx_q;
    opnd_d   = pickOperands(vecCnt_d, lfsrA_d, lfsrB_d);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      vecCnt_q <= '0;
      opIdx_q  <= '0;
      lfsrA_q  <= '0;
      lfsrB_q  <= '0;
      sig_q    <= '0;
      opcode_q <= ALU_SLL;
      op1_q    <= '0;
      op2_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= RUN;
            lfsrA_q  <= SEED;
            lfsrB_q  <= SEED_B;
            sig_q    <= '0;
            vecCnt_q <= '0;
            opIdx_q  <= '0;
            opcode_q <= ALU_SLL;
            op1_q    <= 32'h7FFF_FFFF;
            op2_q    <= 32'h0000_0001;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        RUN: begin
          sig_q   <= sig_d;
          lfsrA_q <= lfsrA_d;
          lfsrB_q <= lfsrB_d;
          if (lastVec && lastOp) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            pass_q   <= (sig_d == GOLDEN_SIG);
            opcode_q <= ALU_SLL;
            op1_q    <= '0;
            op2_q    <= '0;
          end else begin
            vecCnt_q <= vecCnt_d;
            opIdx_q  <= opIdx_d;
            opcode_q <= aluop_t'(opIdx_d);
            op1_q    <= opnd_d[63:32];
            op2_q    <= opnd_d[31:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign opcode    = opcode_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign shamt     = op2_q[4:0];

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: attaches a behavioural ALU, walks each run cycle by cycle
// against directed vectors and an LFSR/MISR reference, and exercises fault, restart and reset cases.

module tb_alu_bist;
  import alu_bist_pkg::*;

  localparam int          NV      = 6;
  localparam int          TOTAL   = 10 * NV;
  localparam logic [31:0] SEED    = 32'h1D87_2B41;
  localparam int          FAULT_K = 3 * NV + 5;

  function automatic logic [31:0] tbStep(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  // Result in [34:3], then flags n, z, v.
  function automatic logic [34:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic        ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      4'd0: r = a << sh;
      4'd1: r = a >> sh;
      4'd2: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd3: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~(a | b);
      4'd8: r = {31'b0, $signed(a) < $signed(b)};
      4'd9: r = {31'b0, a < b};
      default: r = '0;
    endcase
    return {r, r[31], (r == 32'h0), ovf};
  endfunction

  function automatic logic [63:0] tbOperands(input int v, input logic [31:0] a,
                                             input logic [31:0] b);
    case (v)
      0:       return {32'h7FFF_FFFF, 32'h0000_0001};
      1:       return {32'h8000_0000, 32'h8000_0000};
      2:       return {32'h0000_0000, 32'h0000_0000};
      3:       return {32'hFFFF_FFFF, 32'h0000_001F};
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [31:0] refSignature();
    logic [31:0] a, b, sig, x, y;
    logic [34:0] o;
    a   = SEED;
    b   = {SEED[15:0], SEED[31:16]};
    sig = '0;
    for (int k = 0; k < TOTAL; k++) begin
      {x, y} = tbOperands(k % NV, a, b);
      o      = aluModel(4'(k / NV), x, y, y[4:0]);
      sig    = tbStep(sig) ^ o[34:3] ^ {29'b0, o[2:0]};
      a      = tbStep(a);
      b      = tbStep(b);
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLDEN = refSignature();

  logic        CLK, nRST, start;
  logic        busy, done, pass;
  logic [31:0] signature, op1, op2, res;
  aluop_t      opcode;
  logic [4:0]  shamt;
  logic        flag_n, flag_z, flag_v;
  logic        injectFault, faultHit;
  logic [31:0] aluRes;
  int          tbCycle;
  int          nChecks, nFail;

  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED), .GOLDEN_SIG(GOLDEN)) dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .opcode(opcode), .op1(op1), .op2(op2), .shamt(shamt),
    .res(res), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle index within the current run, used to aim the injected fault at one vector.
  always @(posedge CLK) tbCycle <= busy ? tbCycle + 1 : 0;

  always_comb begin
    faultHit = injectFault && busy && (tbCycle == FAULT_K) && (opcode == ALU_SUB);
    {aluRes, flag_n, flag_z, flag_v} = aluModel(opcode, op1, op2, shamt);
    res = aluRes ^ {31'b0, faultHit};
  end

  typedef struct {
    int          cyc;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s (cycle %0d): actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, ".busy"}, -1, 32'(busy), 32'd0);
    checkOutput({name, ".done"}, -1, 32'(done), 32'd0);
    checkOutput({name, ".pass"}, -1, 32'(pass), 32'd0);
    checkOutput({name, ".signature"}, -1, signature, 32'd0);
    checkOutput({name, ".opcode"}, -1, {28'b0, opcode}, 32'd0);
    checkOutput({name, ".op1"}, -1, op1, 32'd0);
    checkOutput({name, ".op2"}, -1, op2, 32'd0);
    checkOutput({name, ".shamt"}, -1, 32'(shamt), 32'd0);
  endtask

  // One complete run; skipArm means start is already high and the next edge is the start edge.
  task automatic applyStimulus(input bit skipArm, input bit keepStart, input bit fault);
    logic [31:0] a, b, ea, eb;
    injectFault = fault;
    if (!skipArm) begin
      @(negedge CLK);
      start = 1'b1;
    end
    @(posedge CLK);
    a = SEED;
    b = {SEED[15:0], SEED[31:16]};
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge CLK);
      if (k == 0 && !keepStart) start = 1'b0;
      {ea, eb} = tbOperands(k % NV, a, b);
      checkOutput("run.busy", k, 32'(busy), 32'd1);
      checkOutput("run.done", k, 32'(done), 32'd0);
      checkOutput("run.opcode", k, {28'b0, opcode}, 32'(k / NV));
      checkOutput("run.op1", k, op1, ea);
      checkOutput("run.op2", k, op2, eb);
      checkOutput("run.shamt", k, 32'(shamt), 32'(eb[4:0]));
      for (int i = 0; i < 12; i++) begin
        if (vecs[i].cyc == k) begin
          checkOutput("vec.opcode", k, {28'b0, opcode}, {28'b0, vecs[i].op});
          checkOutput("vec.op1", k, op1, vecs[i].a);
          checkOutput("vec.op2", k, op2, vecs[i].b);
          checkOutput("vec.res", k, res, vecs[i].r);
          checkOutput("vec.flags", k, {29'b0, flag_n, flag_z, flag_v}, {29'b0, vecs[i].f});
        end
      end
      a = tbStep(a);
      b = tbStep(b);
    end
    @(negedge CLK);
    checkOutput("end.busy", TOTAL, 32'(busy), 32'd0);
    checkOutput("end.done", TOTAL, 32'(done), 32'd1);
    checkOutput("end.opcode", TOTAL, {28'b0, opcode}, 32'd0);
    checkOutput("end.op1", TOTAL, op1, 32'd0);
    if (fault) begin
      checkOutput("fault.pass", TOTAL, 32'(pass), 32'd0);
      nChecks++;
      if (signature === GOLDEN) begin
        nFail++;
        $display("[TB] FAIL fault.signature: actual %h required a value other than %h",
                 signature, GOLDEN);
      end
    end else begin
      checkOutput("end.pass", TOTAL, 32'(pass), 32'd1);
      checkOutput("end.signature", TOTAL, signature, GOLDEN);
    end
    injectFault = 1'b0;
  endtask

  initial begin
    nChecks     = 0;
    nFail       = 0;
    injectFault = 1'b0;
    nRST        = 1'b0;
    start       = 1'b1;

    vecs[0]  = '{0,  4'd0, 32'h7FFF_FFFF, 32'h1,         32'hFFFF_FFFE, 3'b100};
    vecs[1]  = '{1,  4'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b100};
    vecs[2]  = '{3,  4'd0, 32'hFFFF_FFFF, 32'h1F,        32'h8000_0000, 3'b100};
    vecs[3]  = '{6,  4'd1, 32'h7FFF_FFFF, 32'h1,         32'h3FFF_FFFF, 3'b000};
    vecs[4]  = '{12, 4'd2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b101};
    vecs[5]  = '{13, 4'd2, 32'h8000_0000, 32'h8000_0000, 32'h0,         3'b011};
    vecs[6]  = '{18, 4'd3, 32'h7FFF_FFFF, 32'h1,         32'h7FFF_FFFE, 3'b000};
    vecs[7]  = '{20, 4'd3, 32'h0,         32'h0,         32'h0,         3'b010};
    vecs[8]  = '{21, 4'd3, 32'hFFFF_FFFF, 32'h1F,        32'hFFFF_FFE0, 3'b100};
    vecs[9]  = '{42, 4'd7, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b100};
    vecs[10] = '{51, 4'd8, 32'hFFFF_FFFF, 32'h1F,        32'h1,         3'b000};
    vecs[11] = '{57, 4'd9, 32'hFFFF_FFFF, 32'h1F,        32'h0,         3'b010};

    // Reset held with start high must leave every output quiet.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkReset("reset");
    start = 1'b0;
    nRST  = 1'b1;
    @(negedge CLK);
    checkReset("idle");

    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // start held high: no mid-run restart, then an immediate restart out of DONE.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("doneHold.done", -1, 32'(done), 32'd1);
    checkOutput("doneHold.signature", -1, signature, GOLDEN);

    // Reset in the middle of the ALU_XOR vectors, then a clean full run.
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (6 * NV + 2) @(negedge CLK);
    checkOutput("midRun.opcode", 6 * NV + 2, {28'b0, opcode}, 32'd6);
    nRST = 1'b0;
    #1;
    checkReset("midRunReset");
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
